logic_reduce_unit: RTL

Parametrised, registered successor to the team's 2-input gate primitives. Combines LANES words of WIDTH bits with a selectable bitwise operator, accumulates that lane-reduced value across a multi-beat burst, and presents one result per burst. The unit sits between a valid/ready producer and a valid/ready consumer.

---
 rtl/logic_ops_pkg.sv | 41 ++++
 rtl/lane_reduce.sv | 29 ++
 rtl/logic_reduce_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/logic_ops_pkg.sv
// Shared operator and state encodings for the lane-reduction unit.
// base_of() maps each operator onto the AND/OR/XOR primitive that it folds with.
package logic_ops_pkg;

    typedef enum logic [2:0] {
        OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_RSV6, OP_RSV7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE, S_ACCUM, S_HOLD
    } state_e;

    localparam logic [1:0] BASE_AND = 2'd0;
    localparam logic [1:0] BASE_OR  = 2'd1;
    localparam logic [1:0] BASE_XOR = 2'd2;

    // Per-bit identity of each base operator; replicated to the lane width by users.
    localparam logic ID_AND = 1'b1;
    localparam logic ID_OR  = 1'b0;
    localparam logic ID_XOR = 1'b0;

    function automatic logic [1:0] base_of(input op_e op);
        logic [1:0] b;
        b = BASE_OR;
        case (op)
            OP_AND, OP_NAND: b = BASE_AND;
            OP_XOR, OP_XNOR: b = BASE_XOR;
            default:         b = BASE_OR;
        endcase
        return b;
    endfunction

    function automatic logic inv_of(input op_e op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    function automatic logic rsv_of(input op_e op);
        return (op == OP_RSV6) || (op == OP_RSV7);
    endfunction

endpackage

// File: rtl/lane_reduce.sv
// Combinational fold of LANES words of WIDTH bits with a selectable base operator.
// Starting from the operator's identity makes LANES=1 a plain pass-through.
module lane_reduce
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic [1:0]             base_sel,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic [WIDTH-1:0]       beat
);

    always_comb begin
        case (base_sel)
            BASE_AND: beat = {WIDTH{ID_AND}};
            BASE_XOR: beat = {WIDTH{ID_XOR}};
            default:  beat = {WIDTH{ID_OR}};
        endcase
        for (int k = 0; k < LANES; k++) begin
            case (base_sel)
                BASE_AND: beat = beat & in_data[k*WIDTH +: WIDTH];
                BASE_XOR: beat = beat ^ in_data[k*WIDTH +: WIDTH];
                default:  beat = beat | in_data[k*WIDTH +: WIDTH];
            endcase
        end
    end

endmodule

// File: rtl/logic_reduce_unit.sv
// Burst reducer: folds lanes per beat, accumulates beats, holds one result per burst.
// Handshakes: a beat moves on in_valid&&in_ready, a result on out_valid&&out_ready; in_ready depends only on state.
module logic_reduce_unit
    import logic_ops_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [2:0]             in_op,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [CNT_W-1:0]       out_count,
    output logic                   out_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             dbg_state
);

    state_e           state_q, state_d;
    logic             rdy_en_q;
    logic [1:0]       base_q;
    logic             inv_q;
    logic             err_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       base_sel;
    logic [WIDTH-1:0] beat;
    logic             accept;

    // The first beat of a burst folds with the live op; later beats use the latched one.
    assign base_sel = (state_q == S_IDLE) ? base_of(op_e'(in_op)) : base_q;

    lane_reduce #(.WIDTH(WIDTH), .LANES(LANES)) u_lane_reduce (
        .base_sel (base_sel),
        .in_data  (in_data),
        .beat     (beat)
    );

    // rdy_en_q keeps in_ready low through reset and the edge that releases it.
    assign in_ready  = rdy_en_q && (state_q != S_HOLD);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = inv_q ? ~acc_q : acc_q;
    assign out_count = cnt_q;
    assign out_err   = err_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = in_last ? S_HOLD : S_ACCUM;
            S_ACCUM: if (accept && in_last) state_d = S_HOLD;
            S_HOLD:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rdy_en_q <= 1'b0;
            base_q   <= BASE_OR;
            inv_q    <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            if (accept) begin
                if (state_q == S_IDLE) begin
                    base_q <= base_of(op_e'(in_op));
                    inv_q  <= inv_of(op_e'(in_op));
                    err_q  <= rsv_of(op_e'(in_op));
                    acc_q  <= beat;
                    cnt_q  <= CNT_W'(1);
                end else begin
                    case (base_q)
                        BASE_AND: acc_q <= acc_q & beat;
                        BASE_XOR: acc_q <= acc_q ^ beat;
                        default:  acc_q <= acc_q | beat;
                    endcase
                    if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

endmodule
